// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division; each takes 34 busy cycles.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        we_hi,
  input  logic        we_lo,
  input  logic [31:0] wd,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [63:0] work;        // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic [31:0] opnd;        // multiplicand or divisor magnitude
  logic        is_div, neg_res, neg_rem, div_zero;

  logic        accept, finish, signed_op;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum, div_diff;
  logic [63:0] mul_step, div_step, prod_fix;
  logic [31:0] res_hi, res_lo;

  assign signed_op = ~op[0];
  assign abs_a     = (signed_op && a[31]) ? -a : a;
  assign abs_b     = (signed_op && b[31]) ? -b : b;
  assign accept    = (state == IDLE) && start && !flush;
  assign finish    = (state == FIX) && !flush;
  assign busy      = (state != IDLE);

  // One iteration of each algorithm; a zero divisor naturally shifts the dividend into the remainder.
  assign mul_sum  = {1'b0, work[63:32]} + (work[0] ? {1'b0, opnd} : 33'd0);
  assign mul_step = {mul_sum, work[31:1]};
  assign div_diff = work[63:31] - {1'b0, opnd};
  assign div_step = div_diff[32] ? {work[62:0], 1'b0}
                                 : {div_diff[31:0], work[30:0], 1'b1};

  assign prod_fix = neg_res ? -work : work;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    res_hi = prod_fix[63:32];
    res_lo = prod_fix[31:0];
    if (is_div) begin
      res_hi = neg_rem ? -work[63:32] : work[63:32];
      res_lo = div_zero ? 32'hFFFF_FFFF : (neg_res ? -work[31:0] : work[31:0]);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN: begin
        if (flush)              state_nxt = IDLE;
        else if (cnt == 6'd32)  state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= 6'd0;
      work     <= 64'd0;
      opnd     <= 32'd0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else if (accept) begin
      cnt      <= 6'd0;
      is_div   <= op[1];
      opnd     <= op[1] ? abs_b : abs_a;
      work     <= {32'd0, op[1] ? abs_a : abs_b};
      neg_res  <= signed_op && (a[31] ^ b[31]);
      neg_rem  <= signed_op && a[31];
      div_zero <= op[1] && (b == 32'd0);
    end else if (state == RUN && cnt != 6'd32) begin
      cnt  <= cnt + 6'd1;
      work <= is_div ? div_step : mul_step;
    end
  end

  // An accepted start takes priority over a same-cycle MTHI/MTLO write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done <= 1'b0;
      hi   <= 32'd0;
      lo   <= 32'd0;
    end else begin
      done <= finish;
      if (finish) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (state == IDLE && !accept) begin
        if (we_hi) hi <= wd;
        if (we_lo) lo <= wd;
      end
    end
  end

endmodule
